lu_fetch_unit: RTL



---
 rtl/lu_pkg.sv | 15 +
 rtl/lu_fetch_fifo.sv | 67 ++++++
 rtl/lu_fetch_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the lu fetch front end: reserved instruction
// codes and the fetch sequencer state encoding.
package lu_pkg;

    localparam logic [7:0] HALT_CODE = 8'hFF;
    localparam logic [7:0] NOP_CODE  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/lu_fetch_fifo.sv
// Small synchronous prefetch FIFO with push, pop and flush. Flush wins
// over a same-cycle push or pop; a push into a full FIFO is only accepted
// when a pop frees the slot in the same cycle.
module lu_fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // Entry storage needs no reset: empty entries are never presented.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/lu_fetch_unit.sv
// Instruction fetch stage for lu_processor: loadable program store, PC
// sequencer, one-deep read tracking and a prefetch FIFO feeding ICODE over
// a valid/ready handshake. Fetch stops on a HALT word or at the last
// program address, and can be redirected with a flush while running.
module lu_fetch_unit
    import lu_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int IW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [IW-1:0]              prog_data,
    input  logic                       start,
    input  logic                       redirect,
    input  logic [$clog2(DEPTH)-1:0]   redirect_addr,
    output logic [IW-1:0]              ICODE,
    output logic                       icode_valid,
    input  logic                       icode_ready,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic                       busy,
    output logic                       done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] LAST_ADDR   = PW'(DEPTH - 1);
    localparam logic [CW:0]   FIFO_LIMIT  = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [IW-1:0] store [DEPTH];
    logic [IW-1:0] rd_data;
    logic          inflight;
    logic          inflight_last;
    logic          issued_last;

    logic          issue;
    logic          push;
    logic          pop;
    logic          flush;
    logic          do_start;
    logic          do_redirect;
    logic          store_we;
    logic [CW:0]   occupancy;

    logic [IW-1:0] fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    lu_fetch_fifo #(
        .WIDTH (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rd_data),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign icode_valid = !fifo_empty;
    assign ICODE       = icode_valid ? fifo_head : IW'(NOP_CODE);
    assign pop         = icode_valid && icode_ready;
    assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign store_we    = prog_we && ((state == ST_IDLE) || (state == ST_DONE));

    // Sequencer state, PC and read tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            issued_last   <= 1'b0;
        end else begin
            state         <= state_next;
            inflight      <= issue;
            inflight_last <= issue && (pc == LAST_ADDR);
            if (do_start) begin
                pc          <= '0;
                issued_last <= 1'b0;
            end else if (do_redirect) begin
                pc          <= redirect_addr;
                issued_last <= 1'b0;
            end else if (issue) begin
                if (pc == LAST_ADDR) begin
                    issued_last <= 1'b1;
                end else begin
                    pc <= pc + PW'(1);
                end
            end
        end
    end

    // Program store: kept across reset, synchronous write and one-cycle read.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store[prog_addr] <= prog_data;
        end
        if (issue) begin
            rd_data <= store[pc];
        end
    end

    // Next-state and datapath controls; a returning word is only kept in RUN.
    always_comb begin
        state_next  = state;
        issue       = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        do_start    = 1'b0;
        do_redirect = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    do_start   = 1'b1;
                    flush      = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    do_redirect = 1'b1;
                    flush       = 1'b1;
                end else begin
                    if (inflight) begin
                        if (rd_data == IW'(HALT_CODE)) begin
                            state_next = ST_DRAIN;
                        end else begin
                            push = 1'b1;
                            if (inflight_last) begin
                                state_next = ST_DRAIN;
                            end
                        end
                    end
                    issue = !issued_last && !fifo_full && (occupancy < FIFO_LIMIT);
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    do_redirect = 1'b1;
                    flush       = 1'b1;
                    state_next  = ST_RUN;
                end else if (fifo_empty) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
